evm_ballot_ctrl: RTL and testbench

//  Front-end controller for the votingMachine tally datapath.
//  - Conditions four raw candidate buttons: 2-FF synchroniser plus debounce per button.
//  - Enforces one accepted vote per press and rejects multi-button presses.
//  - Hands each vote to the tally counters over a valid/ready handshake.
//  - In results mode, turns button presses into a display-select for the LED result view.

---
 rtl/evm_pkg.sv | 36 +++
 rtl/evm_debounce.sv | 44 ++++
 rtl/evm_ballot_ctrl.sv | 131 +++++++++++++
 tb/tb_evm_ballot_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/evm_pkg.sv
// Shared types and helpers for the ballot controller: FSM states, candidate sizing,
// and button-vector decoding used by both the FSM and the display capture.
package evm_pkg;

    typedef enum logic [2:0] {
        WAIT_REL,
        ARMED,
        ACCEPT,
        LOCKOUT,
        RESULTS
    } state_t;

    localparam int N_CAND = 4;
    localparam int CAND_W = 2;

    function automatic logic [CAND_W-1:0] cand_index(input logic [N_CAND-1:0] v);
        logic [CAND_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_CAND; i++) begin
            if (v[i]) begin
                idx = CAND_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic multi_press(input logic [N_CAND-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < N_CAND; i++) begin
            n += int'(v[i]);
        end
        return (n > 1);
    endfunction

endpackage

// File: rtl/evm_debounce.sv
// One button conditioner: two-flop synchroniser followed by a stable bit that only
// flips after DEBOUNCE_CYCLES consecutive synced cycles of disagreement.
module evm_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_button,
    output logic o_stable
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    // Any agreeing cycle restarts the count, so a bouncing input never flips the stable bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_button;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_stable) begin
                if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_stable <= r_sync2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/evm_ballot_ctrl.sv
// Ballot front-end: debounced buttons feed an FSM that offers one vote per press to the
// tally datapath, rejects multi-presses, enforces a lockout and drives the results view.
module evm_ballot_ctrl
    import evm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 16,
    parameter int BALLOT_W        = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_mode,
    input  logic [N_CAND-1:0]   i_button,
    input  logic                i_vote_ready,
    output logic                o_vote_valid,
    output logic [CAND_W-1:0]   o_vote_sel,
    output logic                o_invalid,
    output logic                o_busy,
    output logic                o_disp_en,
    output logic [CAND_W-1:0]   o_disp_sel,
    output logic [BALLOT_W-1:0] o_ballot_cnt
);

    localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    logic [N_CAND-1:0]   w_db;
    logic                w_onehot;
    logic                w_multi;
    logic                w_handshake;
    logic                w_invalid;
    state_t              w_next;

    state_t              r_state;
    logic [LOCK_W-1:0]   r_lock_cnt;
    logic [BALLOT_W-1:0] r_ballot;
    logic [CAND_W-1:0]   r_vote_sel;
    logic [CAND_W-1:0]   r_disp_sel;
    logic                r_vote_valid;
    logic                r_invalid;
    logic                r_busy;
    logic                r_disp_en;

    for (genvar g = 0; g < N_CAND; g++) begin : g_db
        evm_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_button (i_button[g]),
            .o_stable (w_db[g])
        );
    end

    assign w_multi     = multi_press(w_db);
    assign w_onehot    = (w_db != '0) && !w_multi;
    assign w_handshake = (r_state == ACCEPT) && i_vote_ready;

    // Results mode overrides every state; a handshake on that same edge still completes.
    always_comb begin
        w_next    = r_state;
        w_invalid = 1'b0;
        case (r_state)
            WAIT_REL: if (w_db == '0) w_next = ARMED;
            ARMED: begin
                if (w_onehot) begin
                    w_next = ACCEPT;
                end else if (w_multi) begin
                    w_next    = WAIT_REL;
                    w_invalid = 1'b1;
                end
            end
            ACCEPT:   if (i_vote_ready) w_next = LOCKOUT;
            LOCKOUT:  if (r_lock_cnt == '0) w_next = WAIT_REL;
            RESULTS:  if (!i_mode) w_next = WAIT_REL;
            default:  w_next = WAIT_REL;
        endcase
        if (i_mode) begin
            w_next    = RESULTS;
            w_invalid = 1'b0;
        end
    end

    // Outputs are registered from the next state so reset forces them all low,
    // even though the FSM itself restarts in WAIT_REL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= WAIT_REL;
            r_lock_cnt   <= '0;
            r_ballot     <= '0;
            r_vote_sel   <= '0;
            r_disp_sel   <= '0;
            r_vote_valid <= 1'b0;
            r_invalid    <= 1'b0;
            r_busy       <= 1'b0;
            r_disp_en    <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_vote_valid <= (w_next == ACCEPT);
            r_invalid    <= w_invalid;
            r_busy       <= (w_next == ACCEPT) || (w_next == LOCKOUT) || (w_next == WAIT_REL);
            r_disp_en    <= (w_next == RESULTS);

            if ((r_state == ARMED) && (w_next == ACCEPT)) begin
                r_vote_sel <= cand_index(w_db);
            end

            if ((r_state != LOCKOUT) && (w_next == LOCKOUT)) begin
                r_lock_cnt <= LOCK_W'(LOCKOUT_CYCLES - 1);
            end else if ((r_state == LOCKOUT) && (r_lock_cnt != '0)) begin
                r_lock_cnt <= r_lock_cnt - LOCK_W'(1);
            end

            if (w_handshake && (r_ballot != {BALLOT_W{1'b1}})) begin
                r_ballot <= r_ballot + BALLOT_W'(1);
            end

            if ((r_state == RESULTS) && w_onehot) begin
                r_disp_sel <= cand_index(w_db);
            end
        end
    end

    assign o_vote_valid = r_vote_valid;
    assign o_vote_sel   = r_vote_sel;
    assign o_invalid    = r_invalid;
    assign o_busy       = r_busy;
    assign o_disp_en    = r_disp_en;
    assign o_disp_sel   = r_disp_sel;
    assign o_ballot_cnt = r_ballot;

endmodule

// File: tb/tb_evm_ballot_ctrl.sv
// Self-checking bench for evm_ballot_ctrl: directed vector table, hand-built corner
// sequences and randomized press episodes scored against a press-level reference model.
module tb_evm_ballot_ctrl;

    localparam int GAP = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_mode;
    logic [3:0]  i_button;
    logic        i_vote_ready;

    logic        o_vote_valid;
    logic [1:0]  o_vote_sel;
    logic        o_invalid;
    logic        o_busy;
    logic        o_disp_en;
    logic [1:0]  o_disp_sel;
    logic [15:0] o_ballot_cnt;

    logic        s_vote_valid;
    logic [1:0]  s_vote_sel;
    logic        s_invalid;
    logic        s_busy;
    logic        s_disp_en;
    logic [1:0]  s_disp_sel;
    logic [1:0]  s_ballot_cnt;

    int          checks = 0;
    int          failures = 0;
    int          validCycles;
    int          handshakes;
    int          invalidPulses;
    logic [1:0]  lastSel;
    logic        prevValid;
    logic [1:0]  prevSel;
    int          modelBallot;
    logic [1:0]  modelDisp;

    typedef struct {
        logic [3:0] btn;
        int         hold;
        int         expVotes;
        int         expInvalid;
        logic [1:0] expSel;
    } vec_t;

    vec_t vecs[7];

    evm_ballot_ctrl #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(16), .BALLOT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_mode       (i_mode),
        .i_button     (i_button),
        .i_vote_ready (i_vote_ready),
        .o_vote_valid (o_vote_valid),
        .o_vote_sel   (o_vote_sel),
        .o_invalid    (o_invalid),
        .o_busy       (o_busy),
        .o_disp_en    (o_disp_en),
        .o_disp_sel   (o_disp_sel),
        .o_ballot_cnt (o_ballot_cnt)
    );

    evm_ballot_ctrl #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(16), .BALLOT_W(2)) dutSat (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_mode       (i_mode),
        .i_button     (i_button),
        .i_vote_ready (i_vote_ready),
        .o_vote_valid (s_vote_valid),
        .o_vote_sel   (s_vote_sel),
        .o_invalid    (s_invalid),
        .o_busy       (s_busy),
        .o_disp_en    (s_disp_en),
        .o_disp_sel   (s_disp_sel),
        .o_ballot_cnt (s_ballot_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference rules at press level: a clean single press is one vote for that
    // candidate, a clean multi-press is one rejection, nothing happens in results mode.
    function automatic void predictEpisode(input logic [3:0] btn, input logic mode,
                                           output int votes, output int invs, output logic [1:0] sel);
        int n = 0;
        sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (btn[i]) begin
                n++;
                sel = 2'(i);
            end
        end
        votes = (!mode && n == 1) ? 1 : 0;
        invs  = (!mode && n > 1) ? 1 : 0;
    endfunction

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic clearCounters();
        validCycles   = 0;
        handshakes    = 0;
        invalidPulses = 0;
        lastSel       = 2'd0;
    endtask

    // One cycle: drive new inputs at the falling edge and record what the next rising edge will see.
    task automatic applyStimulus(input logic [3:0] btn, input logic mode, input logic ready);
        @(negedge clk);
        if (prevValid && !i_vote_ready && o_vote_valid) begin
            checkOutput("sel_stable", 32'(o_vote_sel), 32'(prevSel));
        end
        i_button     = btn;
        i_mode       = mode;
        i_vote_ready = ready;
        checkOutput("valid_and_invalid", 32'(o_vote_valid & o_invalid), 32'd0);
        if (o_vote_valid) validCycles++;
        if (o_invalid) invalidPulses++;
        if (o_vote_valid && ready) begin
            handshakes++;
            lastSel = o_vote_sel;
        end
        prevValid = o_vote_valid;
        prevSel   = o_vote_sel;
    endtask

    task automatic idle(input int n, input logic mode);
        for (int c = 0; c < n; c++) applyStimulus(4'b0000, mode, 1'b1);
    endtask

    task automatic runEpisode(input logic [3:0] btn, input int hold, input logic mode, input bit randReady);
        logic rdy;
        clearCounters();
        for (int c = 0; c < hold + GAP; c++) begin
            rdy = (randReady && c < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
            applyStimulus((c < hold) ? btn : 4'b0000, mode, rdy);
        end
    endtask

    task automatic waitValid(input logic [3:0] btn, input logic mode);
        bit found;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            applyStimulus(btn, mode, 1'b0);
            if (o_vote_valid) found = 1'b1;
        end
        checkOutput("wait_valid", 32'(found), 32'd1);
    endtask

    task automatic checkBallot(input string name);
        checkOutput(name, 32'(o_ballot_cnt), 32'(modelBallot));
        checkOutput("ballot_sat", 32'(s_ballot_cnt), 32'(sat3(modelBallot)));
    endtask

    initial begin
        int         firstValid;
        int         ev;
        int         ei;
        logic [1:0] es;
        logic [3:0] rb;
        int         rh;
        logic       isResults;

        vecs[0] = '{4'b0010, 3, 0, 0, 2'd0};
        vecs[1] = '{4'b0010, 4, 1, 0, 2'd1};
        vecs[2] = '{4'b0110, 10, 0, 1, 2'd0};
        vecs[3] = '{4'b1000, 10, 1, 0, 2'd3};
        vecs[4] = '{4'b0001, 10, 1, 0, 2'd0};
        vecs[5] = '{4'b1111, 6, 0, 1, 2'd0};
        vecs[6] = '{4'b0100, 12, 1, 0, 2'd2};

        rst_n = 1'b0;
        i_mode = 1'b0;
        i_button = 4'b0000;
        i_vote_ready = 1'b1;
        prevValid = 1'b0;
        prevSel = 2'd0;
        modelBallot = 0;
        modelDisp = 2'd0;
        clearCounters();

        repeat (3) @(negedge clk);
        checkOutput("rst_valid", 32'(o_vote_valid), 32'd0);
        checkOutput("rst_invalid", 32'(o_invalid), 32'd0);
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
        checkOutput("rst_disp_en", 32'(o_disp_en), 32'd0);
        checkOutput("rst_ballot", 32'(o_ballot_cnt), 32'd0);
        rst_n = 1'b1;
        idle(3, 1'b0);
        checkOutput("armed_busy", 32'(o_busy), 32'd0);

        // Single held press: vote offered at cycle 7 for one cycle, busy until release.
        clearCounters();
        firstValid = -1;
        for (int c = 0; c < 30; c++) begin
            applyStimulus(4'b0010, 1'b0, 1'b1);
            if (o_vote_valid && firstValid < 0) firstValid = c;
        end
        modelBallot++;
        checkOutput("single_first_valid", 32'(firstValid), 32'd7);
        checkOutput("single_valid_cycles", 32'(validCycles), 32'd1);
        checkOutput("single_sel", 32'(lastSel), 32'd1);
        checkOutput("single_busy_held", 32'(o_busy), 32'd1);
        checkBallot("single_ballot");
        idle(12, 1'b0);
        checkOutput("single_busy_released", 32'(o_busy), 32'd0);
        idle(GAP, 1'b0);

        // Bouncing press never reaches the stable threshold.
        clearCounters();
        for (int c = 0; c < 28; c++) begin
            applyStimulus((c < 3 || (c >= 5 && c < 8)) ? 4'b0001 : 4'b0000, 1'b0, 1'b1);
        end
        checkOutput("bounce_valid", 32'(validCycles), 32'd0);
        checkBallot("bounce_ballot");
        runEpisode(4'b0001, 10, 1'b0, 1'b0);
        modelBallot++;
        checkOutput("bounce_retry_votes", 32'(handshakes), 32'd1);
        checkOutput("bounce_retry_sel", 32'(lastSel), 32'd0);

        for (int i = 0; i < 7; i++) begin
            runEpisode(vecs[i].btn, vecs[i].hold, 1'b0, 1'b0);
            modelBallot += vecs[i].expVotes;
            checkOutput("vec_votes", 32'(handshakes), 32'(vecs[i].expVotes));
            checkOutput("vec_invalid", 32'(invalidPulses), 32'(vecs[i].expInvalid));
            if (vecs[i].expVotes > 0) checkOutput("vec_sel", 32'(lastSel), 32'(vecs[i].expSel));
            checkBallot("vec_ballot");
        end

        // Stall in ACCEPT, then hold the button through lockout.
        clearCounters();
        waitValid(4'b0100, 1'b0);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(4'b0100, 1'b0, 1'b0);
            checkOutput("stall_valid", 32'(o_vote_valid), 32'd1);
            checkOutput("stall_sel", 32'(o_vote_sel), 32'd2);
            checkBallot("stall_ballot");
        end
        for (int c = 0; c < 30; c++) applyStimulus(4'b0100, 1'b0, 1'b1);
        modelBallot++;
        checkOutput("stall_votes", 32'(handshakes), 32'd1);
        checkBallot("stall_after_ballot");
        idle(GAP, 1'b0);
        checkOutput("held_no_second_vote", 32'(handshakes), 32'd1);
        runEpisode(4'b0100, 10, 1'b0, 1'b0);
        modelBallot++;
        checkOutput("repress_votes", 32'(handshakes), 32'd1);
        checkOutput("repress_sel", 32'(lastSel), 32'd2);

        // Results request on the same edge as the handshake still completes the vote.
        clearCounters();
        waitValid(4'b0010, 1'b0);
        applyStimulus(4'b0010, 1'b1, 1'b1);
        applyStimulus(4'b0010, 1'b1, 1'b1);
        modelBallot++;
        checkOutput("mode_ack_valid", 32'(o_vote_valid), 32'd0);
        checkOutput("mode_ack_disp_en", 32'(o_disp_en), 32'd1);
        checkOutput("mode_ack_votes", 32'(handshakes), 32'd1);
        checkBallot("mode_ack_ballot");
        idle(10, 1'b1);
        idle(10, 1'b0);

        // Results request without acknowledge aborts the vote.
        clearCounters();
        waitValid(4'b0001, 1'b0);
        applyStimulus(4'b0001, 1'b1, 1'b0);
        applyStimulus(4'b0001, 1'b1, 1'b0);
        checkOutput("abort_valid", 32'(o_vote_valid), 32'd0);
        checkOutput("abort_disp_en", 32'(o_disp_en), 32'd1);
        checkOutput("abort_votes", 32'(handshakes), 32'd0);
        checkBallot("abort_ballot");
        idle(10, 1'b1);
        for (int c = 0; c < 10; c++) applyStimulus(4'b0100, 1'b1, 1'b1);
        idle(10, 1'b1);
        checkOutput("results_disp_sel", 32'(o_disp_sel), 32'd2);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkOutput("results_exit_disp_en", 32'(o_disp_en), 32'd0);
        checkOutput("results_hold_disp_sel", 32'(o_disp_sel), 32'd2);
        modelDisp = 2'd2;
        idle(10, 1'b0);

        for (int e = 0; e < 24; e++) begin
            isResults = ($urandom_range(0, 4) == 0);
            rb = 4'($urandom_range(1, 15));
            rh = $urandom_range(6, 20);
            predictEpisode(rb, 1'b0, ev, ei, es);
            runEpisode(rb, rh, isResults, !isResults);
            if (isResults) begin
                if (ev == 1) modelDisp = es;
                checkOutput("rand_res_votes", 32'(handshakes), 32'd0);
                checkOutput("rand_res_invalid", 32'(invalidPulses), 32'd0);
                checkOutput("rand_res_disp_en", 32'(o_disp_en), 32'd1);
                checkOutput("rand_res_disp_sel", 32'(o_disp_sel), 32'(modelDisp));
                idle(5, 1'b0);
                checkOutput("rand_res_exit", 32'(o_disp_en), 32'd0);
            end else begin
                modelBallot += ev;
                checkOutput("rand_votes", 32'(handshakes), 32'(ev));
                checkOutput("rand_invalid", 32'(invalidPulses), 32'(ei));
                if (ev == 1) checkOutput("rand_sel", 32'(lastSel), 32'(es));
                checkBallot("rand_ballot");
            end
        end

        // Asynchronous reset in the middle of lockout.
        clearCounters();
        for (int c = 0; c < 12; c++) applyStimulus(4'b0001, 1'b0, 1'b1);
        checkOutput("lock_busy", 32'(o_busy), 32'd1);
        checkOutput("lock_votes", 32'(handshakes), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", 32'(o_vote_valid), 32'd0);
        checkOutput("async_rst_busy", 32'(o_busy), 32'd0);
        checkOutput("async_rst_disp_sel", 32'(o_disp_sel), 32'd0);
        checkOutput("async_rst_vote_sel", 32'(o_vote_sel), 32'd0);
        checkOutput("async_rst_ballot", 32'(o_ballot_cnt), 32'd0);
        checkOutput("async_rst_sat_ballot", 32'(s_ballot_cnt), 32'd0);
        i_button = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        prevValid = 1'b0;
        modelBallot = 0;
        modelDisp = 2'd0;
        idle(3, 1'b0);

        for (int v = 0; v < 5; v++) begin
            runEpisode(4'b0001, 8, 1'b0, 1'b0);
            modelBallot++;
            checkOutput("sat_votes", 32'(handshakes), 32'd1);
            checkBallot("sat_ballot");
        end
        checkOutput("sat_final", 32'(s_ballot_cnt), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
